// File: rtl/ballot_pkg.sv
// Shared types and default timing constants for the ballot unit.
package ballot_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        CAST   = 2'd2,
        LOCKED = 2'd3
    } ballot_state_e;

    localparam int unsigned DEBOUNCE_DEFAULT = 4;
    localparam int unsigned TIMEOUT_DEFAULT  = 1000;

endpackage

// File: rtl/ballot_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one button.
module ballot_debounce
    import ballot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o
);

    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       s1_q, s2_q;
    logic       level_q, level_d;
    logic [7:0] cnt_q, cnt_d;

    // The level flips on the last of DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ballot_unit.sv
// Voting-booth controller: arm, debounce, one vote per arm edge.
// Optional session timeout is built when BALLOT_TIMEOUT_EN is defined.
module ballot_unit
    import ballot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_ballot,
    input  logic btn_a,
    input  logic btn_b,
    output logic vote_a,
    output logic vote_b,
    output logic ready,
    output logic reject,
    output logic timeout
);

    ballot_state_e state_q, state_d;
    logic          en_q;
    logic          choice_q, choice_d;
    logic          hold_q, hold_d;
    logic          db_a, db_b;
    logic          arm;
    logic          none;

    ballot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk_i   (clk),
        .rst_ni  (reset),
        .btn_i   (btn_a),
        .level_o (db_a)
    );

    ballot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk_i   (clk),
        .rst_ni  (reset),
        .btn_i   (btn_b),
        .level_o (db_b)
    );

    assign arm  = enable_ballot & ~en_q;
    assign none = ~db_a & ~db_b;

`ifdef BALLOT_TIMEOUT_EN
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        to_cnt_d = TO_LOAD;
        if (state_q == ARMED && to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - 16'd1;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        choice_d = choice_q;
        hold_d   = hold_q;
        vote_a   = 1'b0;
        vote_b   = 1'b0;
        ready    = 1'b0;
        reject   = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                hold_d = 1'b0;
                if (arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                ready = 1'b1;
                // After a double press, wait for a full release before accepting a choice.
                if (db_a && db_b) begin
                    reject = ~hold_q;
                    hold_d = 1'b1;
                end else if (none) begin
                    hold_d = 1'b0;
                end else if (!hold_q) begin
                    state_d  = CAST;
                    choice_d = db_b;
                end
`ifdef BALLOT_TIMEOUT_EN
                if (state_d == ARMED && to_cnt_q == '0) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            CAST: begin
                vote_a  = ~choice_q;
                vote_b  = choice_q;
                state_d = LOCKED;
            end
            LOCKED: begin
                if (none) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // en_q resets high so a level held through reset is not taken as an arm edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            en_q     <= 1'b1;
            choice_q <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= enable_ballot;
            choice_q <= choice_d;
            hold_q   <= hold_d;
        end
    end

`ifdef BALLOT_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q  <= TO_LOAD;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    // Always 0 over the legal budget range; no session expiry in this build.
    assign timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_ballot_unit.sv
// Scoreboard bench for ballot_unit: expected pulses queued by stimulus, checked by a monitor.
module tb_ballot_unit;

    localparam int DEB = 4;
    localparam int TO  = 20;

    typedef struct {
        logic [3:0] kind;
        int         cyc;
    } exp_t;

    localparam logic [3:0] EV_A   = 4'b0001;
    localparam logic [3:0] EV_B   = 4'b0010;
    localparam logic [3:0] EV_REJ = 4'b0100;
    localparam logic [3:0] EV_TO  = 4'b1000;

    logic clk = 1'b0;
    logic reset;
    logic enable_ballot;
    logic btn_a, btn_b;
    logic vote_a, vote_b, ready, reject, timeout;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   cnt_a  = 0;
    int   cnt_b  = 0;
    exp_t exp_q[$];

    ballot_unit #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_ballot(enable_ballot),
        .btn_a        (btn_a),
        .btn_b        (btn_b),
        .vote_a       (vote_a),
        .vote_b       (vote_b),
        .ready        (ready),
        .reject       (reject),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input logic [3:0] kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [3:0] ev;
        exp_t       e;
        ev = {timeout, reject, vote_b, vote_a};
        if (ev != 4'b0000) begin
            checks++;
            if (vote_a) cnt_a++;
            if (vote_b) cnt_b++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %b at cycle %0d, required none", ev, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != ev || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL event: got %b at cycle %0d, required %b at cycle %0d",
                             ev, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    initial begin
        int n;
        reset         = 1'b0;
        enable_ballot = 1'b0;
        btn_a         = 1'b0;
        btn_b         = 1'b0;

        step(3);
        chk("reset_outputs", int'({vote_a, vote_b, ready, reject, timeout}), 0);
        reset = 1'b1;
        step(2);
        chk("idle_ready", int'(ready), 0);

        // Single vote for A, seven cycles after the press.
        enable_ballot = 1'b1;
        step(1);
        enable_ballot = 1'b0;
        chk("armed_ready", int'(ready), 1);
        n = cyc;
        btn_a = 1'b1;
        expect_ev(EV_A, n + DEB + 3);
        step(10);
        btn_a = 1'b0;
        chk("ready_after_vote", int'(ready), 0);
        step(10);
        chk("count_a_first", cnt_a, 1);
        chk("count_b_first", cnt_b, 0);

`ifndef BALLOT_TIMEOUT_EN
        // Short glitch on B is filtered; enable stays high from here on.
        enable_ballot = 1'b1;
        step(1);
        btn_b = 1'b1;
        step(2);
        btn_b = 1'b0;
        step(12);
        chk("glitch_stays_armed", int'(ready), 1);

        // Double press: one reject, then a clean B vote after release.
        n = cyc;
        btn_a = 1'b1;
        btn_b = 1'b1;
        expect_ev(EV_REJ, n + DEB + 2);
        step(8);
        btn_a = 1'b0;
        btn_b = 1'b0;
        step(10);
        chk("armed_after_reject", int'(ready), 1);
        n = cyc;
        btn_b = 1'b1;
        expect_ev(EV_B, n + DEB + 3);
        step(10);
        btn_b = 1'b0;
        chk("ready_after_vote_b", int'(ready), 0);

        // Long hold and repeated presses without a new arm edge.
        step(2);
        btn_a = 1'b1;
        step(50);
        btn_a = 1'b0;
        step(5);
        for (int i = 0; i < 3; i++) begin
            btn_a = 1'b1;
            btn_b = (i == 1);
            step(6);
            btn_a = 1'b0;
            btn_b = 1'b0;
            step(8);
        end
        chk("no_rearm_ready", int'(ready), 0);
        chk("count_a_locked", cnt_a, 1);
        chk("count_b_locked", cnt_b, 1);
        enable_ballot = 1'b0;
`endif

        // Reset during the CAST cycle suppresses the vote.
        step(2);
        enable_ballot = 1'b1;
        step(1);
        enable_ballot = 1'b0;
        btn_a = 1'b1;
        step(DEB + 3);
        chk("cast_reached", int'(vote_a), 1);
        reset = 1'b0;
        #1;
        chk("reset_in_cast", int'({vote_a, vote_b, ready, reject, timeout}), 0);
        step(2);
        btn_a = 1'b0;
        reset = 1'b1;
        step(20);
        chk("idle_after_reset", int'(ready), 0);

        // Recovery requires a fresh arm edge.
        enable_ballot = 1'b1;
        step(1);
        enable_ballot = 1'b0;
        n = cyc;
        btn_a = 1'b1;
        expect_ev(EV_A, n + DEB + 3);
        step(10);
        btn_a = 1'b0;
        step(20);
        chk("count_a_final", cnt_a, 2);

`ifdef BALLOT_TIMEOUT_EN
        // Session expiry, then a press that must not vote.
        n = cyc;
        enable_ballot = 1'b1;
        expect_ev(EV_TO, n + 1 + TO);
        step(1);
        enable_ballot = 1'b0;
        step(TO + 5);
        chk("ready_after_timeout", int'(ready), 0);
        btn_a = 1'b1;
        step(10);
        btn_a = 1'b0;
        step(15);
        chk("count_a_timeout", cnt_a, 2);
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
